// File: rtl/stream_mux_arb_if.sv
// Stream bundle for stream_mux_arb: N packed input channels merged onto one
// registered output port. 'slave' is the mux side, 'master' is the environment side.
interface stream_mux_arb_if #(
  parameter int SIZE     = 32,
  parameter int CHANNELS = 4
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*SIZE-1:0] in_data;
  logic [CHANNELS-1:0]      in_valid;
  logic [CHANNELS-1:0]      in_last;
  logic [CHANNELS-1:0]      in_ready;
  logic [SIZE-1:0]          out_data;
  logic                     out_last;
  logic [SELW-1:0]          out_sel;
  logic                     out_valid;
  logic                     out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_sel, out_valid
  );
endinterface

// File: rtl/stream_mux_arb.sv
// N-channel stream multiplexer with fixed-priority or round-robin arbitration,
// packet locking until a last beat, and one registered output stage.
module stream_mux_arb #(
  parameter int SIZE     = 32,
  parameter int CHANNELS = 4,
  parameter bit RR       = 1'b1
) (
  input logic              clk,
  input logic              rst,
  stream_mux_arb_if.slave  bus
);
  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;
  logic [SIZE-1:0] out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic            out_valid_q, out_valid_d;

  logic                load_en;
  logic                winner_valid;
  logic                xfer;
  logic [SELW-1:0]     winner;
  logic [CHANNELS-1:0] ready;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin : arbitrate
    int              cand;
    logic [SELW-1:0] cand_sel;
    winner       = '0;
    winner_valid = 1'b0;
    cand         = 0;
    cand_sel     = '0;
    if (state_q == LOCKED) begin
      winner       = lock_ch_q;
      winner_valid = bus.in_valid[lock_ch_q];
    end else begin
      // Round-robin scans upward from rr_ptr with wrap; fixed priority scans from 0.
      for (int j = 0; j < CHANNELS; j++) begin
        cand = RR ? (int'(rr_ptr_q) + j) : j;
        if (cand >= CHANNELS) cand = cand - CHANNELS;
        cand_sel = SELW'(cand);
        if (!winner_valid && bus.in_valid[cand_sel]) begin
          winner_valid = 1'b1;
          winner       = cand_sel;
        end
      end
    end
  end

  // Grants are suppressed while rst is high so no upstream beat is consumed and lost.
  assign load_en = !out_valid_q || bus.out_ready;
  assign xfer    = load_en && winner_valid && !rst;

  always_comb begin : grant_vec
    ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ready[i] = xfer && (winner == SELW'(i));
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_sel_d   = winner;
      out_last_d  = bus.in_last[winner];
      for (int i = 0; i < CHANNELS; i++) begin
        if (winner == SELW'(i)) out_data_d = bus.in_data[i*SIZE +: SIZE];
      end
      if (bus.in_last[winner]) begin
        state_d = IDLE;
        if (RR) rr_ptr_d = (winner == LAST_CH) ? '0 : winner + 1'b1;
      end else begin
        state_d   = LOCKED;
        lock_ch_d = winner;
      end
    end else if (load_en) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_stream_mux_arb.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share one
// randomized input stream; a rule-level model predicts grants and output beats.
module tb_stream_mux_arb;
  localparam int SIZE = 32;
  localparam int CH   = 4;
  localparam int SELW = 2;

  typedef struct {
    logic [SIZE-1:0] data;
    logic            last;
    int              sel;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH*SIZE-1:0] in_data  = '0;
  logic [CH-1:0]      in_valid = '0;
  logic [CH-1:0]      in_last  = '0;
  logic               out_ready = 1'b1;

  always #5 clk = ~clk;

  stream_mux_arb_if #(.SIZE(SIZE), .CHANNELS(CH)) if_rr ();
  stream_mux_arb_if #(.SIZE(SIZE), .CHANNELS(CH)) if_fp ();

  assign if_rr.in_data   = in_data;
  assign if_rr.in_valid  = in_valid;
  assign if_rr.in_last   = in_last;
  assign if_rr.out_ready = out_ready;
  assign if_fp.in_data   = in_data;
  assign if_fp.in_valid  = in_valid;
  assign if_fp.in_last   = in_last;
  assign if_fp.out_ready = out_ready;

  stream_mux_arb #(.SIZE(SIZE), .CHANNELS(CH), .RR(1'b1)) u_rr (.clk(clk), .rst(rst), .bus(if_rr));
  stream_mux_arb #(.SIZE(SIZE), .CHANNELS(CH), .RR(1'b0)) u_fp (.clk(clk), .rst(rst), .bus(if_fp));

  // Index 0 = round-robin instance, index 1 = fixed-priority instance.
  logic [CH-1:0]   dut_ready [2];
  logic            dut_valid [2];
  logic [SIZE-1:0] dut_data  [2];
  logic            dut_last  [2];
  logic [SELW-1:0] dut_sel   [2];
  assign dut_ready[0] = if_rr.in_ready;
  assign dut_valid[0] = if_rr.out_valid;
  assign dut_data[0]  = if_rr.out_data;
  assign dut_last[0]  = if_rr.out_last;
  assign dut_sel[0]   = if_rr.out_sel;
  assign dut_ready[1] = if_fp.in_ready;
  assign dut_valid[1] = if_fp.out_valid;
  assign dut_data[1]  = if_fp.out_data;
  assign dut_last[1]  = if_fp.out_last;
  assign dut_sel[1]   = if_fp.out_sel;

  int checks = 0;
  int errors = 0;

  beat_t q_rr[$];
  beat_t q_fp[$];

  // Reference model state: output occupied, packet owner, round-robin start.
  bit m_busy   [2];
  bit m_locked [2];
  int m_lock   [2];
  int m_ptr    [2];

  function automatic string nm(input int d);
    return (d == 0) ? "rr" : "fp";
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_locked[d] = 0; m_lock[d] = 0; m_ptr[d] = 0;
    end
    q_rr.delete();
    q_fp.delete();
  endtask

  // Called just before a rising edge with inputs stable.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit            can_load;
      bit            found;
      int            w;
      int            k;
      logic [CH-1:0] exp_rdy;
      beat_t         b;
      can_load = !m_busy[d] || out_ready;
      found = 0;
      w = 0;
      if (m_locked[d]) begin
        w = m_lock[d];
        found = in_valid[w];
      end else begin
        for (int j = 0; j < CH; j++) begin
          k = (d == 0) ? (m_ptr[d] + j) % CH : j;
          if (!found && in_valid[k]) begin found = 1; w = k; end
        end
      end
      exp_rdy = '0;
      if (can_load && found) exp_rdy[w] = 1'b1;
      check($sformatf("in_ready_%s", nm(d)), dut_ready[d], exp_rdy);
      check($sformatf("out_valid_%s", nm(d)), dut_valid[d], m_busy[d]);
      if (exp_rdy != '0) begin
        b.data = in_data[w*SIZE +: SIZE];
        b.last = in_last[w];
        b.sel  = w;
        if (d == 0) q_rr.push_back(b); else q_fp.push_back(b);
        if (in_last[w]) begin
          m_locked[d] = 0;
          if (d == 0) m_ptr[d] = (w + 1) % CH;
        end else begin
          m_locked[d] = 1;
          m_lock[d]   = w;
        end
      end
      if (can_load) m_busy[d] = (exp_rdy != '0);
    end
  endtask

  task automatic set_in(input logic [CH-1:0] v, input logic [CH-1:0] l,
                        input int base, input bit ordy);
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    for (int i = 0; i < CH; i++) in_data[i*SIZE +: SIZE] = SIZE'(base + i);
  endtask

  task automatic tick();
    #4;
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    set_in('1, '1, 32'h11, 1'b1);
    for (int c = 0; c < n; c++) begin
      #4;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("rst_in_ready_%s", nm(d)), dut_ready[d], '0);
        if (c > 0) begin
          check($sformatf("rst_out_valid_%s", nm(d)), dut_valid[d], 0);
          check($sformatf("rst_out_data_%s", nm(d)), dut_data[d], 0);
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: pops the scoreboard whenever an output beat is accepted.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          if (dut_valid[d] && out_ready) begin
            if (((d == 0) ? q_rr.size() : q_fp.size()) == 0) begin
              check($sformatf("sb_spurious_%s", nm(d)), 1, 0);
            end else begin
              b = (d == 0) ? q_rr.pop_front() : q_fp.pop_front();
              check($sformatf("sb_data_%s", nm(d)), dut_data[d], b.data);
              check($sformatf("sb_last_%s", nm(d)), dut_last[d], b.last);
              check($sformatf("sb_sel_%s", nm(d)), dut_sel[d], b.sel);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CH-1:0] l;
    do_reset(2);

    // Round-robin rotation over four single-beat requesters.
    for (int c = 0; c < 5; c++) begin
      set_in(4'b1111, 4'b1111, 32'hA0, 1'b1);
      tick();
      check("rr_rotation_data", dut_data[0], 32'hA0 + (c % 4));
    end

    // Fixed priority: ch1 beats ch3 every cycle until ch1 drops.
    for (int c = 0; c < 6; c++) begin
      set_in(4'b1010, 4'b1111, 32'hB0, 1'b1);
      tick();
      check("fp_sel_ch1", dut_sel[1], 1);
    end
    for (int c = 0; c < 2; c++) begin
      set_in(4'b1000, 4'b1111, 32'hB0, 1'b1);
      tick();
      check("fp_sel_ch3", dut_sel[1], 3);
    end

    // Packet lock on ch2 with a valid gap while ch0 keeps requesting.
    set_in(4'b0100, 4'b0000, 32'hC0, 1'b1); tick();
    set_in(4'b0001, 4'b0000, 32'hC8, 1'b1);
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("lock_gap_ready_%s", nm(d)), dut_ready[d], 4'b0000);
    #3; model_step(); @(negedge clk);
    set_in(4'b0101, 4'b0000, 32'hD0, 1'b1); tick();
    set_in(4'b0101, 4'b0100, 32'hD8, 1'b1); tick();
    set_in(4'b0001, 4'b0001, 32'hE0, 1'b1);
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("lock_release_ready_%s", nm(d)), dut_ready[d], 4'b0001);
    #3; model_step(); @(negedge clk);

    // Backpressure: 0x55 is held for three stalled cycles, then drained with no bubble.
    set_in(4'b0001, 4'b0001, 32'h55, 1'b1); tick();
    for (int c = 0; c < 3; c++) begin
      set_in(4'b0011, 4'b0011, 32'h60, 1'b0);
      tick();
      for (int d = 0; d < 2; d++) check($sformatf("stall_hold_%s", nm(d)), dut_data[d], 32'h55);
    end
    for (int c = 0; c < 2; c++) begin
      set_in(4'b0010, 4'b0010, 32'h70, 1'b1);
      tick();
    end

    // Reset in the middle of a ch1 packet; ch0 must win first afterwards.
    set_in(4'b0010, 4'b0000, 32'h30, 1'b1); tick();
    do_reset(1);
    for (int d = 0; d < 2; d++) check($sformatf("midrst_out_valid_%s", nm(d)), dut_valid[d], 0);
    set_in(4'b0011, 4'b0011, 32'h40, 1'b1);
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("midrst_first_ready_%s", nm(d)), dut_ready[d], 4'b0001);
    #3; model_step(); @(negedge clk);

    // Randomized traffic with random packet lengths and backpressure.
    for (int c = 0; c < 3000; c++) begin
      l = '0;
      for (int i = 0; i < CH; i++) l[i] = ($urandom_range(2) == 0);
      set_in(CH'($urandom), l, 0, ($urandom_range(3) != 0));
      for (int i = 0; i < CH; i++) in_data[i*SIZE +: SIZE] = $urandom;
      tick();
    end

    for (int c = 0; c < 4; c++) begin
      set_in('0, '0, 0, 1'b1);
      tick();
    end
    check("sb_empty_rr", q_rr.size(), 0);
    check("sb_empty_fp", q_fp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
